// File: rtl/axis_stream_checker.sv
// Passive AXI-Stream packet checker: per-packet byte length, length/channel window, tkeep legality, tid stability.
// Latency: the tlast beat at edge N updates counters, last_len_o, err_flags_o and the pulses at edge N+1.
// Backpressure: none applied; tready is only observed, and a beat is tvalid & tready.
//
// Ports: clk/reset_n (async active-low); s_axis_* monitored stream; cfg_* limits (cfg_auto_i picks
// window or fixed-value checks); clear_i synchronous clear; rd_ch_i/rd_bin_i select registered
// read-back on rd_ch_cnt_o/rd_bin_cnt_o; pkt_cnt_o, err_pkt_cnt_o, ovf_ch_cnt_o saturating counters;
// last_len_o, sticky err_flags_o {keep,id,ch,len}, pkt_done_o/pkt_err_o one-cycle pulses.
// Optional feature: define AXIS_CHK_HIST_EN for the NUM_BINS-entry packet length histogram.
module axis_stream_checker #(
    parameter int ID_WIDTH    = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int TKEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH   = 16,
    parameter int CNT_WIDTH   = 32,
    parameter int NUM_CH      = 16,
    parameter int NUM_BINS    = 32,
    parameter int BIN_SHIFT   = 6
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [ID_WIDTH-1:0]         s_axis_tid_i,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata_i,
    input  logic                        s_axis_tvalid_i,
    input  logic                        s_axis_tready_i,
    input  logic                        s_axis_tlast_i,
    input  logic [TKEEP_WIDTH-1:0]      s_axis_tkeep_i,
    input  logic                        cfg_auto_i,
    input  logic [LEN_WIDTH-1:0]        cfg_fix_len_i,
    input  logic [LEN_WIDTH-1:0]        cfg_min_len_i,
    input  logic [LEN_WIDTH-1:0]        cfg_max_len_i,
    input  logic [ID_WIDTH-1:0]         cfg_fix_ch_i,
    input  logic [ID_WIDTH-1:0]         cfg_min_ch_i,
    input  logic [ID_WIDTH-1:0]         cfg_max_ch_i,
    input  logic                        clear_i,
    input  logic [ID_WIDTH-1:0]         rd_ch_i,
    input  logic [$clog2(NUM_BINS)-1:0] rd_bin_i,
    output logic [CNT_WIDTH-1:0]        pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]        err_pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]        ovf_ch_cnt_o,
    output logic [CNT_WIDTH-1:0]        rd_ch_cnt_o,
    output logic [CNT_WIDTH-1:0]        rd_bin_cnt_o,
    output logic [LEN_WIDTH-1:0]        last_len_o,
    output logic [3:0]                  err_flags_o,
    output logic                        pkt_done_o,
    output logic                        pkt_err_o
);

    localparam int CH_AW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BIN_AW = $clog2(NUM_BINS);
    localparam logic [ID_WIDTH:0]      NUM_CH_L  = (ID_WIDTH + 1)'(NUM_CH);
    localparam logic [LEN_WIDTH-1:0]   BIN_MAX_L = LEN_WIDTH'(NUM_BINS - 1);
    localparam logic [TKEEP_WIDTH-1:0] KEEP_ONE  = TKEEP_WIDTH'(1);

    typedef enum logic {ST_IDLE, ST_IN_PKT} state_e;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    state_e                 state_q, state_d;
    logic [ID_WIDTH-1:0]    tid_q, tid_d;
    logic [LEN_WIDTH-1:0]   acc_q, acc_d;
    logic [1:0]             err_acc_q, err_acc_d;      // {keep,id} seen so far in this packet
    logic                   done_q, done_d;            // completed packet waiting for its update edge
    logic [LEN_WIDTH-1:0]   done_len_q, done_len_d;
    logic [ID_WIDTH-1:0]    done_tid_q, done_tid_d;
    logic [3:0]             done_err_q, done_err_d;
    logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0]   err_pkt_cnt_q, err_pkt_cnt_d;
    logic [CNT_WIDTH-1:0]   ovf_ch_cnt_q, ovf_ch_cnt_d;
    logic [CNT_WIDTH-1:0]   ch_cnt_q [NUM_CH];
    logic [CNT_WIDTH-1:0]   ch_cnt_d [NUM_CH];
    logic [CNT_WIDTH-1:0]   rd_ch_cnt_q, rd_ch_cnt_d;
    logic [LEN_WIDTH-1:0]   last_len_q, last_len_d;
    logic [3:0]             err_flags_q, err_flags_d;
    logic                   pkt_done_q, pkt_done_d;
    logic                   pkt_err_q, pkt_err_d;

    // Per-beat combinational view of the packet as it would stand after this beat.
    logic                   beat;
    logic                   in_pkt;
    logic [ID_WIDTH-1:0]    pkt_tid;
    logic [TKEEP_WIDTH-1:0] keep_p1;
    logic                   keep_err;
    logic                   id_err;
    logic                   ch_err;
    logic                   len_err;
    logic [LEN_WIDTH:0]     len_sum;
    logic [LEN_WIDTH-1:0]   len_now;
    logic [1:0]             err_now;
    logic [LEN_WIDTH-1:0]   len_shift;
    logic [BIN_AW-1:0]      bin_idx;
    logic                   done_ch_ok;

    assign beat    = s_axis_tvalid_i & s_axis_tready_i;
    assign in_pkt  = (state_q == ST_IN_PKT);
    assign pkt_tid = in_pkt ? tid_q : s_axis_tid_i;
    assign keep_p1 = s_axis_tkeep_i + KEEP_ONE;
    // A legal last-beat tkeep is a non-zero run of ones from bit 0, i.e. k & (k+1) == 0.
    assign keep_err = s_axis_tlast_i ? ((s_axis_tkeep_i == '0) || ((s_axis_tkeep_i & keep_p1) != '0))
                                     : (s_axis_tkeep_i != '1);
    assign id_err  = in_pkt && (s_axis_tid_i != tid_q);
    assign err_now = (in_pkt ? err_acc_q : 2'b00) | {keep_err, id_err};

    always_comb begin
        len_sum = {1'b0, (in_pkt ? acc_q : '0)};
        for (int i = 0; i < TKEEP_WIDTH; i++) begin
            len_sum = len_sum + (LEN_WIDTH + 1)'(s_axis_tkeep_i[i]);
        end
    end
    assign len_now = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];

    // Channel and length are judged with the config present on the tlast beat.
    assign ch_err  = cfg_auto_i ? ((pkt_tid < cfg_min_ch_i) || (pkt_tid > cfg_max_ch_i))
                                : (pkt_tid != cfg_fix_ch_i);
    assign len_err = cfg_auto_i ? ((len_now < cfg_min_len_i) || (len_now > cfg_max_len_i))
                                : (len_now != cfg_fix_len_i);

    assign done_ch_ok = ({1'b0, done_tid_q} < NUM_CH_L);
    assign len_shift  = done_len_q >> BIN_SHIFT;
    assign bin_idx    = (len_shift >= BIN_MAX_L) ? BIN_AW'(NUM_BINS - 1) : len_shift[BIN_AW-1:0];

`ifdef AXIS_CHK_HIST_EN
    logic [CNT_WIDTH-1:0] hist_q [NUM_BINS];
    logic [CNT_WIDTH-1:0] hist_d [NUM_BINS];
    logic [CNT_WIDTH-1:0] rd_bin_cnt_q, rd_bin_cnt_d;
    logic                 unused_ok;

    assign unused_ok    = ^s_axis_tdata_i;
    assign rd_bin_cnt_o = rd_bin_cnt_q;

    always_comb begin
        hist_d = hist_q;
        if (done_q) begin
            hist_d[bin_idx] = sat_inc(hist_q[bin_idx]);
        end
        rd_bin_cnt_d = hist_q[rd_bin_i];
        if (clear_i) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                hist_d[i] = '0;
            end
            rd_bin_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                hist_q[i] <= '0;
            end
            rd_bin_cnt_q <= '0;
        end else begin
            hist_q       <= hist_d;
            rd_bin_cnt_q <= rd_bin_cnt_d;
        end
    end
`else
    logic unused_ok;

    assign unused_ok    = ^{s_axis_tdata_i, rd_bin_i, bin_idx};
    assign rd_bin_cnt_o = '0;
`endif

    always_comb begin
        state_d       = state_q;
        tid_d         = tid_q;
        acc_d         = acc_q;
        err_acc_d     = err_acc_q;
        done_d        = 1'b0;
        done_len_d    = done_len_q;
        done_tid_d    = done_tid_q;
        done_err_d    = done_err_q;
        pkt_cnt_d     = pkt_cnt_q;
        err_pkt_cnt_d = err_pkt_cnt_q;
        ovf_ch_cnt_d  = ovf_ch_cnt_q;
        ch_cnt_d      = ch_cnt_q;
        last_len_d    = last_len_q;
        err_flags_d   = err_flags_q;
        pkt_done_d    = 1'b0;
        pkt_err_d     = 1'b0;
        rd_ch_cnt_d   = ({1'b0, rd_ch_i} < NUM_CH_L) ? ch_cnt_q[rd_ch_i[CH_AW-1:0]] : '0;

        if (beat) begin
            tid_d = pkt_tid;
            if (s_axis_tlast_i) begin
                state_d    = ST_IDLE;
                acc_d      = '0;
                err_acc_d  = '0;
                done_d     = 1'b1;
                done_len_d = len_now;
                done_tid_d = pkt_tid;
                done_err_d = {err_now, ch_err, len_err};
            end else begin
                state_d   = ST_IN_PKT;
                acc_d     = len_now;
                err_acc_d = err_now;
            end
        end

        if (done_q) begin
            pkt_cnt_d   = sat_inc(pkt_cnt_q);
            last_len_d  = done_len_q;
            err_flags_d = err_flags_q | done_err_q;
            pkt_done_d  = 1'b1;
            pkt_err_d   = |done_err_q;
            if (|done_err_q) begin
                err_pkt_cnt_d = sat_inc(err_pkt_cnt_q);
            end
            if (done_ch_ok) begin
                ch_cnt_d[done_tid_q[CH_AW-1:0]] = sat_inc(ch_cnt_q[done_tid_q[CH_AW-1:0]]);
            end else begin
                ovf_ch_cnt_d = sat_inc(ovf_ch_cnt_q);
            end
        end

        // Clear wins over everything: it drops a pending completion and any beat in this cycle.
        if (clear_i) begin
            state_d       = ST_IDLE;
            tid_d         = '0;
            acc_d         = '0;
            err_acc_d     = '0;
            done_d        = 1'b0;
            pkt_cnt_d     = '0;
            err_pkt_cnt_d = '0;
            ovf_ch_cnt_d  = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_cnt_d[i] = '0;
            end
            last_len_d    = '0;
            err_flags_d   = '0;
            pkt_done_d    = 1'b0;
            pkt_err_d     = 1'b0;
            rd_ch_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            tid_q         <= '0;
            acc_q         <= '0;
            err_acc_q     <= '0;
            done_q        <= 1'b0;
            done_len_q    <= '0;
            done_tid_q    <= '0;
            done_err_q    <= '0;
            pkt_cnt_q     <= '0;
            err_pkt_cnt_q <= '0;
            ovf_ch_cnt_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_cnt_q[i] <= '0;
            end
            rd_ch_cnt_q   <= '0;
            last_len_q    <= '0;
            err_flags_q   <= '0;
            pkt_done_q    <= 1'b0;
            pkt_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tid_q         <= tid_d;
            acc_q         <= acc_d;
            err_acc_q     <= err_acc_d;
            done_q        <= done_d;
            done_len_q    <= done_len_d;
            done_tid_q    <= done_tid_d;
            done_err_q    <= done_err_d;
            pkt_cnt_q     <= pkt_cnt_d;
            err_pkt_cnt_q <= err_pkt_cnt_d;
            ovf_ch_cnt_q  <= ovf_ch_cnt_d;
            ch_cnt_q      <= ch_cnt_d;
            rd_ch_cnt_q   <= rd_ch_cnt_d;
            last_len_q    <= last_len_d;
            err_flags_q   <= err_flags_d;
            pkt_done_q    <= pkt_done_d;
            pkt_err_q     <= pkt_err_d;
        end
    end

    assign pkt_cnt_o     = pkt_cnt_q;
    assign err_pkt_cnt_o = err_pkt_cnt_q;
    assign ovf_ch_cnt_o  = ovf_ch_cnt_q;
    assign rd_ch_cnt_o   = rd_ch_cnt_q;
    assign last_len_o    = last_len_q;
    assign err_flags_o   = err_flags_q;
    assign pkt_done_o    = pkt_done_q;
    assign pkt_err_o     = pkt_err_q;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Directed bench for axis_stream_checker: a default-width instance and a CNT_WIDTH=4 instance
// watch the same stream; expected values are hand-computed constants.
module tb_axis_stream_checker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  tid;
    logic [31:0] tdata;
    logic        tvalid, tready, tlast;
    logic [3:0]  tkeep;
    logic        cfg_auto;
    logic [15:0] fix_len, min_len, max_len;
    logic [9:0]  fix_ch, min_ch, max_ch;
    logic        clear;
    logic [9:0]  rd_ch;
    logic [4:0]  rd_bin;

    logic [31:0] pkt_cnt, err_pkt_cnt, ovf_cnt, rd_ch_cnt, rd_bin_cnt;
    logic [15:0] last_len;
    logic [3:0]  flags;
    logic        pkt_done, pkt_err;

    logic [3:0]  s_pkt_cnt, s_err_pkt_cnt, s_ovf_cnt, s_rd_ch_cnt, s_rd_bin_cnt;
    logic [15:0] s_last_len;
    logic [3:0]  s_flags;
    logic        s_pkt_done, s_pkt_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_stream_checker u_dut (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tid_i(tid), .s_axis_tdata_i(tdata), .s_axis_tvalid_i(tvalid),
        .s_axis_tready_i(tready), .s_axis_tlast_i(tlast), .s_axis_tkeep_i(tkeep),
        .cfg_auto_i(cfg_auto), .cfg_fix_len_i(fix_len), .cfg_min_len_i(min_len),
        .cfg_max_len_i(max_len), .cfg_fix_ch_i(fix_ch), .cfg_min_ch_i(min_ch),
        .cfg_max_ch_i(max_ch), .clear_i(clear), .rd_ch_i(rd_ch), .rd_bin_i(rd_bin),
        .pkt_cnt_o(pkt_cnt), .err_pkt_cnt_o(err_pkt_cnt), .ovf_ch_cnt_o(ovf_cnt),
        .rd_ch_cnt_o(rd_ch_cnt), .rd_bin_cnt_o(rd_bin_cnt), .last_len_o(last_len),
        .err_flags_o(flags), .pkt_done_o(pkt_done), .pkt_err_o(pkt_err)
    );

    axis_stream_checker #(.CNT_WIDTH(4)) u_small (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tid_i(tid), .s_axis_tdata_i(tdata), .s_axis_tvalid_i(tvalid),
        .s_axis_tready_i(tready), .s_axis_tlast_i(tlast), .s_axis_tkeep_i(tkeep),
        .cfg_auto_i(cfg_auto), .cfg_fix_len_i(fix_len), .cfg_min_len_i(min_len),
        .cfg_max_len_i(max_len), .cfg_fix_ch_i(fix_ch), .cfg_min_ch_i(min_ch),
        .cfg_max_ch_i(max_ch), .clear_i(clear), .rd_ch_i(rd_ch), .rd_bin_i(rd_bin),
        .pkt_cnt_o(s_pkt_cnt), .err_pkt_cnt_o(s_err_pkt_cnt), .ovf_ch_cnt_o(s_ovf_cnt),
        .rd_ch_cnt_o(s_rd_ch_cnt), .rd_bin_cnt_o(s_rd_bin_cnt), .last_len_o(s_last_len),
        .err_flags_o(s_flags), .pkt_done_o(s_pkt_done), .pkt_err_o(s_pkt_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [9:0] t, input logic [3:0] k, input logic l);
        tid    = t;
        tkeep  = k;
        tlast  = l;
        tdata  = $urandom;
        tvalid = 1'b1;
        tready = 1'b1;
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    // nfull all-ones beats followed by a tlast beat with keep lk
    task automatic pkt(input logic [9:0] t, input int nfull, input logic [3:0] lk);
        for (int i = 0; i < nfull; i++) beat(t, 4'hF, 1'b0);
        beat(t, lk, 1'b1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1; tid = '0; tdata = '0; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
        tkeep = '0; cfg_auto = 1'b1; fix_len = 16'd20; min_len = 16'd64; max_len = 16'd1600;
        fix_ch = 10'd7; min_ch = 10'd0; max_ch = 10'd15; clear = 1'b0; rd_ch = 10'd5; rd_bin = '0;
        #2 reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // reset state
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_err_cnt", err_pkt_cnt, 0);
        chk("rst_flags", flags, 0);
        chk("rst_last_len", last_len, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_rd_bin", rd_bin_cnt, 0);

        // 3 beats tid 5, keep F,F,3 -> 10 bytes, below min length
        pkt(10'd5, 2, 4'h3);
        tick();
        chk("a_done", pkt_done, 1);
        chk("a_err", pkt_err, 1);
        chk("a_flags", flags, 4'b0001);
        chk("a_len", last_len, 10);
        chk("a_pkt_cnt", pkt_cnt, 1);
        chk("a_err_cnt", err_pkt_cnt, 1);
        tick();
        chk("a_done_pulse_end", pkt_done, 0);
        chk("a_ch5", rd_ch_cnt, 1);
        do_clear();
        chk("clr1_pkt_cnt", pkt_cnt, 0);
        chk("clr1_flags", flags, 0);
        chk("clr1_len", last_len, 0);
        tick();
        chk("clr1_ch5", rd_ch_cnt, 0);

        // 16 x F + last 7, tid 2 -> 67 bytes, clean
        rd_ch = 10'd2;
        pkt(10'd2, 16, 4'h7);
        tick();
        chk("b_len", last_len, 67);
        chk("b_pkt_cnt", pkt_cnt, 1);
        chk("b_err_cnt", err_pkt_cnt, 0);
        chk("b_done", pkt_done, 1);
        chk("b_err", pkt_err, 0);
        tick();
        chk("b_ch2", rd_ch_cnt, 1);

        // tid 3 with beat 2 carrying tid 4 -> id error, counted on captured channel 3
        beat(10'd3, 4'hF, 1'b0);
        beat(10'd4, 4'hF, 1'b0);
        pkt(10'd3, 14, 4'hF);
        tick();
        chk("c_flags", flags, 4'b0100);
        chk("c_err_cnt", err_pkt_cnt, 1);
        chk("c_pkt_cnt", pkt_cnt, 2);
        rd_ch = 10'd3;
        tick();
        chk("c_ch3", rd_ch_cnt, 1);

        // tid 20 -> outside window and beyond the per-channel counters
        pkt(10'd20, 16, 4'hF);
        tick();
        chk("d_ovf", ovf_cnt, 1);
        chk("d_flags", flags, 4'b0110);
        chk("d_err_cnt", err_pkt_cnt, 2);

        // last beat keep 5 is not contiguous -> keep error, length 66 in window
        pkt(10'd1, 16, 4'h5);
        tick();
        chk("e_flags", flags, 4'b1110);
        chk("e_err", pkt_err, 1);
        chk("e_len", last_len, 66);

        // tready low for 10 cycles mid-packet, even with tlast shown -> no beats counted
        for (int i = 0; i < 8; i++) beat(10'd6, 4'hF, 1'b0);
        tid = 10'd6; tkeep = 4'hF; tlast = 1'b1; tvalid = 1'b1; tready = 1'b0;
        repeat (10) tick();
        chk("f_stall_pkt_cnt", pkt_cnt, 4);
        pkt(10'd6, 8, 4'hF);
        tick();
        chk("f_len", last_len, 68);
        chk("f_pkt_cnt", pkt_cnt, 5);
        chk("f_err_cnt", err_pkt_cnt, 3);

        // fixed mode: fix_len 20, fix_ch 7
        cfg_auto = 1'b0;
        pkt(10'd7, 4, 4'hF);
        tick();
        chk("g_done", pkt_done, 1);
        chk("g_err", pkt_err, 0);
        chk("g_len", last_len, 20);
        pkt(10'd7, 5, 4'hF);
        tick();
        chk("h_err", pkt_err, 1);
        chk("h_flags", flags, 4'b1111);
        chk("h_err_cnt", err_pkt_cnt, 4);

        // 20 single-beat good packets: 4-bit counters saturate at 15
        fix_len = 16'd4; fix_ch = 10'd0;
        for (int i = 0; i < 20; i++) beat(10'd0, 4'hF, 1'b1);
        tick();
        chk("sat_pkt_cnt", pkt_cnt, 27);
        chk("sat_small_pkt_cnt", s_pkt_cnt, 15);
        chk("sat_small_err_cnt", s_err_pkt_cnt, 4);
        chk("sat_err_cnt", err_pkt_cnt, 4);
        rd_ch = 10'd0;
        tick();
        chk("sat_ch0", rd_ch_cnt, 20);

        do_clear();
        chk("clr2_pkt_cnt", pkt_cnt, 0);
        chk("clr2_ovf", ovf_cnt, 0);
        chk("clr2_flags", flags, 0);
        chk("clr2_small_pkt_cnt", s_pkt_cnt, 0);
        tick();
        chk("clr2_ch0", rd_ch_cnt, 0);

        // clear in the update cycle drops the packet
        cfg_auto = 1'b1;
        pkt(10'd2, 16, 4'h7);
        do_clear();
        chk("clrlast_done", pkt_done, 0);
        chk("clrlast_pkt_cnt", pkt_cnt, 0);
        tick();
        chk("clrlast_pkt_cnt2", pkt_cnt, 0);
        chk("clrlast_len", last_len, 0);

        // async reset mid-packet aborts it; the following packet starts fresh
        for (int i = 0; i < 8; i++) beat(10'd2, 4'hF, 1'b0);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        pkt(10'd2, 16, 4'h7);
        tick();
        chk("arst_len", last_len, 67);
        chk("arst_pkt_cnt", pkt_cnt, 1);
        chk("arst_err_cnt", err_pkt_cnt, 0);

        // histogram: lengths 64, 100, 1600 -> bins 1, 1, 25
        do_clear();
        pkt(10'd0, 15, 4'hF);
        pkt(10'd0, 24, 4'hF);
        pkt(10'd0, 399, 4'hF);
        tick();
        chk("hist_len", last_len, 1600);
        rd_bin = 5'd1;
        tick();
`ifdef AXIS_CHK_HIST_EN
        chk("hist_bin1", rd_bin_cnt, 2);
`else
        chk("hist_bin1_off", rd_bin_cnt, 0);
`endif
        rd_bin = 5'd0;
        tick();
        chk("hist_bin0", rd_bin_cnt, 0);
        rd_bin = 5'd25;
        tick();
`ifdef AXIS_CHK_HIST_EN
        chk("hist_bin25", rd_bin_cnt, 1);
`else
        chk("hist_bin25_off", rd_bin_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
